// File: rtl/agex_pkg.sv
// Shared definitions for the AGEX-stage multiplier: default widths and the
// controller state type.
package agex_pkg;

   localparam int DBITS     = 32;
   localparam int REGNOBITS = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/agex_mul_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// shifting multiplier. One partial product is folded in per step.
// Optional feature: MUL_EARLY_TERM_EN reports when the remaining multiplier
// bits are all zero, so the controller can stop iterating early.
module agex_mul_dp #(
   parameter int DBITS = agex_pkg::DBITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [DBITS-1:0] opnd_a,
   input  logic [DBITS-1:0] opnd_b,
   output logic [DBITS-1:0] acc_next,
   output logic             mplier_empty
);

   logic [DBITS-1:0] acc;
   logic [DBITS-1:0] mcand;
   logic [DBITS-1:0] mplier;

   // Accumulator value after the current step (wraps modulo 2^DBITS).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      acc_next = acc;
      if (mplier[0]) acc_next = acc + mcand;
   end

`ifdef MUL_EARLY_TERM_EN
   // Nothing left to add once the multiplier shifted by this step is zero.
   assign mplier_empty = (mplier[DBITS-1:1] == '0);
`else
   assign mplier_empty = 1'b0;
`endif

   // Load fresh operands, or advance one shift-add iteration.
   // NOTE: reset is asynchronous (in the sensitivity list), so it acts without a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= opnd_a;
         mplier <= opnd_b;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/agex_mul_ctrl.sv
// Iterative MUL controller for the AGEX stage. Runs a shift-add multiply
// over DBITS cycles while stalling the front end, then pulses res_valid for
// one cycle with the low DBITS bits of the product.
// Optional feature: MUL_EARLY_TERM_EN ends the run as soon as the remaining
// multiplier bits are zero (at least one iteration is always performed).
module agex_mul_ctrl #(
   parameter int DBITS     = 32,
   parameter int REGNOBITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DBITS-1:0]     opnd_a,
   input  logic [DBITS-1:0]     opnd_b,
   input  logic [REGNOBITS-1:0] wregno_in,
   input  logic                 flush,
   output logic                 stall,
   output logic                 res_valid,
   output logic [DBITS-1:0]     result,
   output logic [REGNOBITS-1:0] res_wregno,
   output logic [31:0]          mul_count
);

   import agex_pkg::*;

   localparam int CNT_BITS = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(DBITS - 1);

   mul_state_t           state;
   logic [CNT_BITS-1:0]  iter_cnt;
   logic [REGNOBITS-1:0] wregno_cap;
   logic [DBITS-1:0]     acc_next;
   logic                 mplier_empty;
   logic                 load;
   logic                 step;
   logic                 last_iter;

   // A start is taken only when not iterating and not being killed.
   assign load      = (state != RUN) && start && !flush;
   assign step      = (state == RUN);
   assign last_iter = (iter_cnt == LAST_ITER) || mplier_empty;

   agex_mul_dp #(
      .DBITS(DBITS)
   ) u_dp (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .step         (step),
      .opnd_a       (opnd_a),
      .opnd_b       (opnd_b),
      .acc_next     (acc_next),
      .mplier_empty (mplier_empty)
   );

   // Controller FSM with registered stall/result outputs and completion counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         iter_cnt   <= '0;
         wregno_cap <= '0;
         stall      <= 1'b0;
         res_valid  <= 1'b0;
         result     <= '0;
         res_wregno <= '0;
         mul_count  <= '0;
      end else begin
         res_valid <= 1'b0;
         // The result pulse now ending counts even if a flush arrives with it.
         if (res_valid) mul_count <= mul_count + 32'd1;

         if (flush) begin
            state <= IDLE;
            stall <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  iter_cnt <= iter_cnt + CNT_BITS'(1);
                  if (last_iter) begin
                     state      <= DONE;
                     stall      <= 1'b0;
                     res_valid  <= 1'b1;
                     result     <= acc_next;
                     res_wregno <= wregno_cap;
                  end
               end
               default: begin
                  if (start) begin
                     state      <= RUN;
                     stall      <= 1'b1;
                     iter_cnt   <= '0;
                     wregno_cap <= wregno_in;
                  end else begin
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_agex_mul_ctrl.sv
// Directed bench for agex_mul_ctrl. Expected results are queued when an
// operation is issued and popped when the result pulse appears.
module tb_agex_mul_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;
   logic [4:0]  wregno_in;
   logic        stall;
   logic        res_valid;
   logic [31:0] result;
   logic [4:0]  res_wregno;
   logic [31:0] mul_count;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  wregno;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mcount_model = '0;

   agex_mul_ctrl #(
      .DBITS     (32),
      .REGNOBITS (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .opnd_a     (opnd_a),
      .opnd_b     (opnd_b),
      .wregno_in  (wregno_in),
      .flush      (flush),
      .stall      (stall),
      .res_valid  (res_valid),
      .result     (result),
      .res_wregno (res_wregno),
      .mul_count  (mul_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Negedges from the accepting edge until res_valid is seen.
   function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      int iters = 1;
      for (int i = 1; i < 32; i++) if (b[i]) iters = i + 1;
      return iters + 1;
`else
      return 33;
`endif
   endfunction

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
      exp_t e;
      e.result = a * b;
      e.wregno = w;
      e.lat    = exp_latency(b);
      sb.push_back(e);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
      @(negedge clk);
      start     = 1'b1;
      opnd_a    = a;
      opnd_b    = b;
      wregno_in = w;
      push_exp(a, b, w);
   endtask

   // Wait for the result pulse, then compare it against the scoreboard head.
   // Returns positioned at the negedge inside the DONE cycle.
   task automatic run_pulse(input string tag, input bit drop_start);
      int   lat      = -1;
      bit   stall_ok = 1'b1;
      exp_t e;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1 && drop_start) start = 1'b0;
         if (res_valid) begin
            lat = k;
            break;
         end
         if (!stall) stall_ok = 1'b0;
      end
      if (lat < 0) check({tag, "_timeout"}, res_valid, 1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, sb.size(), 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_latency"}, lat, e.lat);
         check({tag, "_result"}, result, e.result);
         check({tag, "_wregno"}, res_wregno, e.wregno);
      end
      check({tag, "_stall_run"}, stall_ok, 1);
      check({tag, "_stall_done"}, stall, 0);
      mcount_model++;
   endtask

   initial begin
      exp_t dropped;
      reset     = 1'b1;
      start     = 1'b0;
      flush     = 1'b0;
      opnd_a    = '0;
      opnd_b    = '0;
      wregno_in = '0;
      repeat (3) @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_result", result, 0);
      check("rst_wregno", res_wregno, 0);
      check("rst_count", mul_count, 0);
      reset = 1'b0;

      // Basic multiply.
      issue(32'd7, 32'd6, 5'd3);
      run_pulse("mul7x6", 1'b1);
      @(negedge clk);
      check("pulse_one_cycle", res_valid, 0);
      check("count_after_first", mul_count, mcount_model);

      // Product wraps modulo 2^32.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
      run_pulse("mul_wrap", 1'b1);
      @(negedge clk);
      check("count_after_wrap", mul_count, mcount_model);

      // Flush sampled at the tenth edge after acceptance kills the operation.
      issue(32'd123, 32'd456, 5'd4);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         check("flush_running", res_valid, 0);
         if (k == 9) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle_stall", stall, 0);
      check("flush_no_pulse", res_valid, 0);
      dropped = sb.pop_front();
      issue(32'd100, 32'd200, 5'd5);
      run_pulse("after_flush", 1'b1);
      @(negedge clk);
      check("count_after_flush", mul_count, mcount_model);

      // Asynchronous reset in the middle of a run.
      issue(32'd55, 32'd66, 5'd6);
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_reset_stall", stall, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_stall", stall, 0);
      check("async_rst_res_valid", res_valid, 0);
      check("async_rst_result", result, 0);
      check("async_rst_wregno", res_wregno, 0);
      check("async_rst_count", mul_count, 0);
      dropped      = sb.pop_front();
      mcount_model = '0;
      @(negedge clk);
      reset = 1'b0;

      // Back-to-back: start held through RUN and DONE.
      issue(32'd11, 32'd13, 5'd7);
      run_pulse("b2b_first", 1'b0);
      opnd_a    = 32'd3;
      opnd_b    = 32'd5;
      wregno_in = 5'd9;
      push_exp(32'd3, 32'd5, 5'd9);
      run_pulse("b2b_second", 1'b1);
      @(negedge clk);
      check("count_after_b2b", mul_count, mcount_model);

      // Flush during DONE: pulse stands, count advances, simultaneous start blocked.
      issue(32'd21, 32'd2, 5'd10);
      run_pulse("flush_in_done", 1'b1);
      flush  = 1'b1;
      start  = 1'b1;
      opnd_a = 32'd8;
      opnd_b = 32'd8;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      check("flush_done_stall", stall, 0);
      check("flush_done_valid", res_valid, 0);
      check("flush_done_count", mul_count, mcount_model);

      // Flush together with start in IDLE keeps the controller idle.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_blocks_start", stall, 0);

      // Multiplier patterns that matter for early termination.
      issue(32'd9, 32'd1, 5'd1);
      run_pulse("mul9x1", 1'b1);
      issue(32'd2, 32'h8000_0000, 5'd2);
      run_pulse("mul_msb", 1'b1);
      issue(32'd12345, 32'd0, 5'd3);
      run_pulse("mul_zero", 1'b1);
      @(negedge clk);
      check("count_final", mul_count, mcount_model);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
